// File: rtl/stft_frame_buffer.sv
// Overlapping STFT frame builder: 2N-deep circular sample buffer, N-sample frames at hop N/2.
// Define STFT_FRAME_DROP_EN to tie oIREADY high and drop samples on overflow (sticky oOVF).
module stft_frame_buffer #(
    parameter int WL   = 8,
    parameter int LOGN = 6
) (
    input  logic            iCLK,
    input  logic            iRST,
    input  logic            iCLR,
    input  logic            iVALID,
    input  logic [WL-1:0]   iDATA,
    output logic            oIREADY,
    output logic            oVALID,
    input  logic            iREADY,
    output logic [WL-1:0]   oDATA,
    output logic            oFIRST,
    output logic            oLAST,
    output logic [15:0]     oFRAME,
    output logic            oOVF
);

    localparam int unsigned N  = 1 << LOGN;
    localparam int unsigned H  = N / 2;
    localparam int unsigned D  = 2 * N;
    localparam int unsigned PW = LOGN + 1;
    localparam int unsigned CW = LOGN + 2;

    typedef enum logic {S_IDLE, S_READ} state_t;

    logic [WL-1:0]  r_mem [D];
    state_t         r_state, w_state_nxt;
    logic [PW-1:0]  r_wp, w_wp_nxt;
    logic [PW-1:0]  r_fs, w_fs_nxt;
    logic [PW-1:0]  r_rd_idx, w_rd_idx_nxt;
    logic [CW-1:0]  r_cnt, w_cnt_nxt;
    logic           r_valid, w_valid_nxt;
    logic           r_first, w_first_nxt;
    logic           r_last, w_last_nxt;
    logic           r_ovf, w_ovf_nxt;
    logic [WL-1:0]  r_data, w_data_nxt;
    logic [15:0]    r_frame, w_frame_nxt;

    logic           w_ready;
    logic           w_accept;
    logic           w_drop;
    logic           w_hs;
    logic           w_frame_end;
    logic [PW-1:0]  w_rd_addr;

    assign w_ready   = (r_cnt < CW'(D));
    assign w_accept  = iVALID && w_ready;
    assign w_hs      = r_valid && iREADY;
    assign w_rd_addr = r_fs + r_rd_idx;

`ifdef STFT_FRAME_DROP_EN
    assign oIREADY = 1'b1;
    assign w_drop  = iVALID && !w_ready;
`else
    assign oIREADY = w_ready;
    assign w_drop  = 1'b0;
`endif

    assign oVALID = r_valid;
    assign oDATA  = r_data;
    assign oFIRST = r_first;
    assign oLAST  = r_last;
    assign oFRAME = r_frame;
    assign oOVF   = r_ovf;

    // Next-state and next-output logic; flush overrides everything.
    always_comb begin
        w_state_nxt  = r_state;
        w_wp_nxt     = r_wp;
        w_fs_nxt     = r_fs;
        w_rd_idx_nxt = r_rd_idx;
        w_cnt_nxt    = r_cnt;
        w_valid_nxt  = r_valid;
        w_first_nxt  = r_first;
        w_last_nxt   = r_last;
        w_ovf_nxt    = r_ovf;
        w_data_nxt   = r_data;
        w_frame_nxt  = r_frame;
        w_frame_end  = 1'b0;

        if (iCLR) begin
            w_state_nxt  = S_IDLE;
            w_wp_nxt     = '0;
            w_fs_nxt     = '0;
            w_rd_idx_nxt = '0;
            w_cnt_nxt    = '0;
            w_valid_nxt  = 1'b0;
            w_first_nxt  = 1'b0;
            w_last_nxt   = 1'b0;
            w_ovf_nxt    = 1'b0;
            w_frame_nxt  = '0;
        end else begin
            if (w_accept) w_wp_nxt = r_wp + PW'(1);
            if (w_drop)   w_ovf_nxt = 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (r_cnt >= CW'(N)) begin
                        w_data_nxt   = r_mem[r_fs];
                        w_valid_nxt  = 1'b1;
                        w_first_nxt  = 1'b1;
                        w_last_nxt   = 1'b0;
                        w_rd_idx_nxt = PW'(1);
                        w_state_nxt  = S_READ;
                    end
                end
                S_READ: begin
                    if (w_hs) begin
                        if (r_last) begin
                            w_valid_nxt = 1'b0;
                            w_first_nxt = 1'b0;
                            w_last_nxt  = 1'b0;
                            w_frame_end = 1'b1;
                            w_fs_nxt    = r_fs + PW'(H);
                            w_frame_nxt = r_frame + 16'd1;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_data_nxt   = r_mem[w_rd_addr];
                            w_rd_idx_nxt = r_rd_idx + PW'(1);
                            w_first_nxt  = 1'b0;
                            w_last_nxt   = (r_rd_idx == PW'(N - 1));
                        end
                    end
                end
            endcase

            // Accept and frame retirement may coincide: net change is +1-H.
            w_cnt_nxt = r_cnt + CW'(w_accept) - (w_frame_end ? CW'(H) : CW'(0));
        end
    end

    // State and output registers.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state  <= S_IDLE;
            r_wp     <= '0;
            r_fs     <= '0;
            r_rd_idx <= '0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_first  <= 1'b0;
            r_last   <= 1'b0;
            r_ovf    <= 1'b0;
            r_data   <= '0;
            r_frame  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_wp     <= w_wp_nxt;
            r_fs     <= w_fs_nxt;
            r_rd_idx <= w_rd_idx_nxt;
            r_cnt    <= w_cnt_nxt;
            r_valid  <= w_valid_nxt;
            r_first  <= w_first_nxt;
            r_last   <= w_last_nxt;
            r_ovf    <= w_ovf_nxt;
            r_data   <= w_data_nxt;
            r_frame  <= w_frame_nxt;
        end
    end

    // Sample storage; contents survive reset and flush.
    always_ff @(posedge iCLK) begin
        if (w_accept && !iCLR) r_mem[r_wp] <= iDATA;
    end

endmodule

// File: tb/tb_stft_frame_buffer.sv
// Directed bench for stft_frame_buffer with N=8, H=4, WL=8.
module tb_stft_frame_buffer;

    localparam int WL   = 8;
    localparam int LOGN = 3;
    localparam int NV   = 35;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iCLR;
    logic        iVALID;
    logic [7:0]  iDATA;
    logic        oIREADY;
    logic        oVALID;
    logic        iREADY;
    logic [7:0]  oDATA;
    logic        oFIRST;
    logic        oLAST;
    logic [15:0] oFRAME;
    logic        oOVF;

    int n_chk = 0;
    int n_err = 0;

    stft_frame_buffer #(.WL(WL), .LOGN(LOGN)) dut (
        .iCLK(iCLK), .iRST(iRST), .iCLR(iCLR), .iVALID(iVALID), .iDATA(iDATA),
        .oIREADY(oIREADY), .oVALID(oVALID), .iREADY(iREADY), .oDATA(oDATA),
        .oFIRST(oFIRST), .oLAST(oLAST), .oFRAME(oFRAME), .oOVF(oOVF)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        logic        vin;
        logic [7:0]  din;
        logic        rdy;
        logic        ev;
        logic [7:0]  ed;
        logic        ef;
        logic        el;
        logic [15:0] efr;
        logic        eir;
    } vec_t;

    typedef struct {
        logic [7:0]  d;
        logic        f;
        logic        l;
        logic [15:0] fr;
    } out_t;

    vec_t vecs[NV];
    out_t q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic do_clear();
        iCLR = 1'b1; iVALID = 1'b0; iREADY = 1'b1;
        tick();
        iCLR = 1'b0;
    endtask

    task automatic feed(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            iVALID = 1'b1; iDATA = 8'(base + i);
            tick();
        end
        iVALID = 1'b0;
    endtask

    // Presents samples base..base+n_in-1 with handshake and captures nout outputs.
    task automatic run(input int n_in, input int base, input int nout, input int maxc, inout int idx);
        logic w;
        q.delete();
        for (int c = 0; c < maxc && q.size() < nout; c++) begin
            if (idx < n_in) begin iVALID = 1'b1; iDATA = 8'(base + idx); end
            else iVALID = 1'b0;
            if (oVALID && iREADY) q.push_back('{oDATA, oFIRST, oLAST, oFRAME});
            w = oIREADY;
            tick();
            if (idx < n_in && w) idx++;
        end
        iVALID = 1'b0;
        chk("collect_count", q.size(), nout);
    endtask

    initial begin
        int idx;
        bit found;

        // Basic framing table: 16 back-to-back samples, iREADY high.
        for (int c = 1; c <= NV; c++) begin
            vec_t v;
            int nend;
            int cnt;
            nend = 0;
            v.vin = (c <= 16); v.din = 8'(c - 1); v.rdy = 1'b1;
            v.ev = 1'b0; v.ed = 8'd0; v.ef = 1'b0; v.el = 1'b0; v.efr = 16'd0;
            for (int f = 0; f < 3; f++) begin
                int s;
                s = 9 + 9 * f;
                if (c >= s && c <= s + 7) begin
                    v.ev = 1'b1; v.ed = 8'(4 * f + c - s);
                    v.ef = (c == s); v.el = (c == s + 7); v.efr = 16'(f);
                end
                if (c >= s + 8) begin nend++; v.efr = 16'(f + 1); end
            end
            cnt = ((c < 16) ? c : 16) - 4 * nend;
            v.eir = (cnt < 16);
            vecs[c - 1] = v;
        end

        iRST = 1'b1; iCLR = 1'b0; iVALID = 1'b0; iDATA = 8'd0; iREADY = 1'b1;
        #1;
        chk("rst_iready", oIREADY, 1);
        chk("rst_valid", oVALID, 0);
        chk("rst_data", oDATA, 0);
        chk("rst_first", oFIRST, 0);
        chk("rst_last", oLAST, 0);
        chk("rst_frame", oFRAME, 0);
        chk("rst_ovf", oOVF, 0);
        tick(); tick();
        iRST = 1'b0;

        for (int i = 0; i < NV; i++) begin
            iVALID = vecs[i].vin; iDATA = vecs[i].din; iREADY = vecs[i].rdy;
            tick();
            chk($sformatf("v%0d_valid", i + 1), oVALID, vecs[i].ev);
            chk($sformatf("v%0d_frame", i + 1), oFRAME, vecs[i].efr);
            chk($sformatf("v%0d_iready", i + 1), oIREADY, vecs[i].eir);
            if (vecs[i].ev) begin
                chk($sformatf("v%0d_data", i + 1), oDATA, vecs[i].ed);
                chk($sformatf("v%0d_first", i + 1), oFIRST, vecs[i].ef);
                chk($sformatf("v%0d_last", i + 1), oLAST, vecs[i].el);
            end
        end
        iVALID = 1'b0;

        // Output stall at sample 3 of frame 0.
        do_clear();
        feed(8, 0);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (oVALID && oDATA == 8'd3) found = 1'b1;
            else tick();
        end
        chk("stall_reach3", found, 1);
        iREADY = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_hold_data", oDATA, 3);
            chk("stall_hold_valid", oVALID, 1);
        end
        iREADY = 1'b1;
        for (int j = 4; j < 8; j++) begin
            tick();
            chk("stall_resume_data", oDATA, j);
            chk("stall_resume_valid", oVALID, 1);
            chk("stall_resume_last", oLAST, (j == 7));
        end

        // Full buffer with output blocked.
        do_clear();
        iREADY = 1'b0;
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            logic w;
            iVALID = 1'b1; iDATA = 8'(idx);
            w = oIREADY;
            tick();
            if (w) idx++;
        end
        iVALID = 1'b0;
`ifdef STFT_FRAME_DROP_EN
        chk("full_ovf", oOVF, 1);
        chk("full_iready", oIREADY, 1);
`else
        chk("full_accepted", idx, 16);
        chk("full_iready", oIREADY, 0);
        chk("full_ovf", oOVF, 0);
`endif
        iREADY = 1'b1;
        run(20, 0, 24, 200, idx);
        for (int k = 0; k < q.size(); k++) begin
            chk("full_data", q[k].d, (k / 8) * 4 + (k % 8));
            chk("full_first", q[k].f, ((k % 8) == 0));
            chk("full_last", q[k].l, ((k % 8) == 7));
        end
`ifdef STFT_FRAME_DROP_EN
        chk("full_ovf_sticky", oOVF, 1);
`else
        chk("full_late_accepts", idx, 20);
`endif

        // Flush during frame 1; the sample presented with iCLR must be discarded.
        do_clear();
        feed(12, 0);
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            if (oVALID && oDATA == 8'd6 && oFRAME == 16'd1) found = 1'b1;
            else tick();
        end
        chk("flush_reach6", found, 1);
        iCLR = 1'b1; iVALID = 1'b1; iDATA = 8'd99;
        tick();
        iCLR = 1'b0; iVALID = 1'b0;
        chk("flush_valid", oVALID, 0);
        chk("flush_frame", oFRAME, 0);
        chk("flush_iready", oIREADY, 1);
        idx = 0;
        run(8, 100, 8, 40, idx);
        for (int k = 0; k < q.size(); k++) begin
            chk("flush_data", q[k].d, 100 + k);
            chk("flush_first", q[k].f, (k == 0));
            chk("flush_last", q[k].l, (k == 7));
            chk("flush_fr", q[k].fr, 0);
        end

        // Asynchronous reset mid-frame.
        do_clear();
        feed(8, 0);
        found = 1'b0;
        for (int c = 0; c < 6 && !found; c++) begin
            if (oVALID) found = 1'b1;
            else tick();
        end
        chk("arst_frame_up", found, 1);
        #2 iRST = 1'b1;
        #1;
        chk("arst_valid", oVALID, 0);
        chk("arst_data", oDATA, 0);
        chk("arst_first", oFIRST, 0);
        chk("arst_last", oLAST, 0);
        chk("arst_frame", oFRAME, 0);
        chk("arst_iready", oIREADY, 1);
        #1 iRST = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (oVALID) found = 1'b1;
        end
        chk("arst_no_resume", found, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/stft_frame_buffer.md
# stft_frame_buffer

Overlapping frame builder for the radar STFT path. It accepts a stream of ADC samples and stores them in a circular buffer of depth 2N. It emits N-sample frames with 50% overlap (hop H = N/2), one sample per handshake, to the windowing/FFT stage and its pipeline registers downstream.

## Interface
- WL, 8: sample word length in bits.
- LOGN, 6: log2 of frame length. N = 2^LOGN, H = N/2, buffer depth 2N. Legal range 2..10.
- iCLK  input  1  clock; all state is updated on the rising edge.
- iRST  input  1  reset; asynchronous, active-high.
- iCLR  input  1  synchronous flush, active-high.
- iVALID  input  1  input sample valid.
- iDATA  input  WL  input sample.
- oIREADY  output  1  buffer can accept a sample.
- oVALID  output  1  output sample valid.
- iREADY  input  1  downstream accepts the output sample.
- oDATA  output  WL  output sample.
- oFIRST  output  1  marks the first sample of a frame.
- oLAST  output  1  marks the last (Nth) sample of a frame.
- oFRAME  output  16  index of the frame being emitted; wraps modulo 2^16.
- oOVF  output  1  sticky overflow flag (see Configuration).

## Operation
- Storage: 2N x WL register array.
- Pointers: write pointer wp and frame-start pointer fs, both LOGN+1 bits (mod 2N).
- Occupancy cnt is LOGN+2 bits, range 0..2N, and counts unconsumed samples measured from fs.
- Input accept: a sample is accepted when iVALID && oIREADY. It is written to mem[wp], then wp++ and cnt++.
- oIREADY = (cnt < 2N). This is combinational from cnt.
- FSM states:
  - IDLE: if cnt >= N, load oDATA = mem[fs], set oVALID = 1 and oFIRST = 1, set rd_idx = 1, go to READ.
  - READ: on oVALID && iREADY:
    - If rd_idx < N: load oDATA = mem[fs+rd_idx], rd_idx++. oFIRST = 0. oLAST = 1 when the loaded sample is index N-1.
    - If the consumed sample had oLAST = 1: oVALID = 0, fs += H, cnt -= H, oFRAME++, go to IDLE.
  - READ without a handshake: oDATA, oVALID, oFIRST and oLAST hold their values.
- Simultaneous accept and frame end in one cycle: cnt becomes cnt + 1 - H. A write to mem[wp] never targets a location in fs..fs+N-1 while cnt < 2N, so no read-write conflict exists.
- Frame k covers input samples k*H .. k*H+N-1 (counted since reset or iCLR).
- iCLR: has priority over every other update. Clears wp, fs, cnt, rd_idx, oFRAME, oOVF, oVALID, oFIRST and oLAST, and forces IDLE. A sample presented in the same cycle is discarded. Memory contents are not cleared.
- Reset values: oVALID = 0, oDATA = 0, oFIRST = 0, oLAST = 0, oFRAME = 0, oOVF = 0, FSM in IDLE, cnt = 0. oIREADY = 1 during and after reset.
- Reset asserted mid-frame aborts the frame immediately. No partial frame resumes afterwards.

## Timing
- Frame latency: the accept that makes cnt = N happens at edge t; oVALID rises after edge t+1.
- Throughput: one output sample per cycle while iREADY = 1.
- Exactly one bubble cycle (oVALID = 0) follows each frame's last sample. A frame therefore occupies N+1 cycles at minimum.
- Sustained input rate must be at most H per (N+1) output cycles. Otherwise the buffer fills.
- oDATA, oFIRST, oLAST and oFRAME are registered and stable while oVALID && !iREADY.
- oIREADY depends only on registered cnt. It has no combinational path from iVALID or iREADY.

## Configuration
- STFT_FRAME_DROP_EN defined:
  - oIREADY is tied to 1, because the ADC cannot be stalled.
  - A sample arriving with iVALID = 1 while cnt = 2N is dropped. wp and cnt are unchanged, and oOVF is set to 1 at that edge.
  - oOVF stays 1 until iRST or iCLR.
- STFT_FRAME_DROP_EN undefined:
  - Backpressure applies via oIREADY = (cnt < 2N).
  - oOVF is constant 0.

## Test plan
All scenarios use LOGN = 3 (N = 8, H = 4) and WL = 8. Input values equal the sample index.
- Basic framing: feed samples 0..15 back-to-back with iREADY = 1 -> frames 0..7, 4..11 and 8..15. oFIRST is set on 0, 4 and 8; oLAST on 7, 11 and 15. oFRAME reads 0, 1, 2. There is one bubble between frames.
- Latency: the 8th sample is accepted at edge t -> oVALID = 1 with oDATA = 0 after edge t+1, and not earlier.
- Output stall: drop iREADY for 5 cycles at sample 3 of frame 0 -> oDATA stays 3 and oVALID stays 1. After release the sequence continues 4..7 with no loss.
- Full buffer: iREADY = 0, feed 20 samples.
  - Without the macro: oIREADY = 0 after 16 accepts. After release, frames 0..7 and 4..11 emit, and samples 16..19 are then accepted.
  - With the macro: samples 16..19 are dropped, oOVF = 1, and frame 2 contains 8..15.
- Flush: assert iCLR mid-frame 1 at oDATA = 6 -> next cycle oVALID = 0 and oFRAME = 0. Feeding 100..107 yields a frame of 100..107 with oFIRST set.
- Async reset: pulse iRST between clock edges while oVALID = 1 -> all outputs go to 0 immediately, and oIREADY = 1.
